// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

    localparam logic [31:0] PC_RESET   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Payload handed to the fetch/decode pipeline register (dataF).
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pcplus4;
        logic               exc_instr;
    } fetch_data_t;

    // Sequential successor; wraps modulo 2^32.
    function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Only word-aligned PCs may go to the instruction port.
    function automatic logic pc_aligned(input logic [PC_W-1:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-port and fetch-output bundle of the fetch unit.
// Latency: n/a (wiring only).
// Backpressure: imem via addr_ok/data_ok, output via f_valid/f_ready.
interface fetch_unit_if;

    // sram-like instruction read port
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_addr_ok;
    logic        imem_data_ok;
    logic [31:0] imem_rdata;

    // fetch -> decode pipeline register
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_instr;
    logic [31:0] f_pcplus4;
    logic        f_exc_instr;

    // fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_addr_ok, imem_data_ok, imem_rdata,
        output f_valid, f_instr, f_pcplus4, f_exc_instr,
        input  f_ready
    );

    // memory / decode side
    modport slave (
        input  imem_req, imem_addr,
        output imem_addr_ok, imem_data_ok, imem_rdata,
        input  f_valid, f_instr, f_pcplus4, f_exc_instr,
        output f_ready
    );

endinterface

// File: rtl/fetch_pc_sel.sv
// Next-PC selection (flush / pending redirect / same-cycle redirect / +4) and pending-target register.
// Latency: next_pc combinational; a redirect is remembered one cycle after it is seen.
// Backpressure: none; a redirect arriving while one is pending is ignored (delay slot rule).
module fetch_pc_sel #(
    parameter logic [31:0] EXC_VECTOR = fetch_unit_pkg::EXC_VECTOR
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] pcbranch,
    input  logic [31:0] pcjump,
    input  logic [31:0] pcjr,
    output logic [31:0] next_pc
);
    import fetch_unit_pkg::*;

    logic        pend_v;
    logic [31:0] pend_pc;
    logic        redir_take;
    logic [31:0] redir_tgt;

    assign redir_take = redirect_valid && (branch_taken || jump);
    assign redir_tgt  = jr ? pcjr : (jump ? pcjump : pcbranch);

    // PC to load when the current fetch is consumed or flushed; a latched
    // target outranks a fresh one, which can only be a protocol violation.
    always_comb begin
        next_pc = pc_plus4(pc);
        if (flush) begin
            next_pc = EXC_VECTOR;
        end else if (pend_v) begin
            next_pc = pend_pc;
        end else if (redir_take) begin
            next_pc = redir_tgt;
        end
    end

    // Remember a redirect until the delay-slot fetch in flight is handed over;
    // on the handover cycle itself the target is used directly instead.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_v  <= 1'b0;
            pend_pc <= '0;
        end else if (flush || advance) begin
            pend_v  <= 1'b0;
        end else if (redir_take && !pend_v) begin
            pend_v  <= 1'b1;
            pend_pc <= redir_tgt;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS fetch stage: owns the PC, issues one imem read at a time, registers the result for decode.
// Latency: request accept -> f_valid is 2 cycles minimum (data_ok cycle + output register).
// Backpressure: holds the output (and issues no new request) while f_valid && !f_ready.
module fetch_unit #(
    parameter logic [31:0] PC_RESET   = fetch_unit_pkg::PC_RESET,
    parameter logic [31:0] EXC_VECTOR = fetch_unit_pkg::EXC_VECTOR
) (
    input  logic                clk,
    input  logic                resetn,
    fetch_unit_if.master        fif,
    input  logic                branch_taken,
    input  logic                jump,
    input  logic                jr,
    input  logic [31:0]         pcbranch,
    input  logic [31:0]         pcjump,
    input  logic [31:0]         pcjr,
    input  logic                redirect_valid,
    input  logic                flush
);
    import fetch_unit_pkg::*;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         req_q;
    logic         discard;
    logic         valid_q;
    fetch_data_t  out_q;
    logic         advance;

    // Decode takes the held instruction this cycle.
    assign advance = (state == HOLD) && fif.f_ready;

    fetch_pc_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_sel (
        .clk            (clk),
        .resetn         (resetn),
        .pc             (pc),
        .flush          (flush),
        .advance        (advance),
        .redirect_valid (redirect_valid),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .jr             (jr),
        .pcbranch       (pcbranch),
        .pcjump         (pcjump),
        .pcjr           (pcjr),
        .next_pc        (next_pc)
    );

    // Fetch sequencer: PC, request, discard flag and output register all move together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            pc      <= PC_RESET;
            req_q   <= 1'b0;
            discard <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else if (flush) begin
            pc      <= next_pc;
            valid_q <= 1'b0;
            case (state)
                WAIT: begin
                    if (fif.imem_data_ok) begin
                        // the stale read returns now; nothing left to drop
                        discard <= 1'b0;
                        req_q   <= pc_aligned(next_pc);
                        state   <= REQ;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                REQ: begin
                    if (req_q && fif.imem_addr_ok) begin
                        // the memory took the old address; its data must be dropped
                        discard <= 1'b1;
                        req_q   <= 1'b0;
                        state   <= WAIT;
                    end else begin
                        req_q   <= pc_aligned(next_pc);
                        state   <= REQ;
                    end
                end
                default: begin
                    req_q <= pc_aligned(next_pc);
                    state <= REQ;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    req_q <= pc_aligned(pc);
                    state <= REQ;
                end
                REQ: begin
                    if (!pc_aligned(pc)) begin
                        // misaligned PC never reaches memory; deliver an address error
                        out_q   <= '{instr: 32'h0, pcplus4: pc_plus4(pc), exc_instr: 1'b1};
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end else if (fif.imem_addr_ok) begin
                        req_q <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (fif.imem_data_ok) begin
                        if (discard) begin
                            discard <= 1'b0;
                            req_q   <= pc_aligned(pc);
                            state   <= REQ;
                        end else begin
                            out_q   <= '{instr: fif.imem_rdata, pcplus4: pc_plus4(pc), exc_instr: 1'b0};
                            valid_q <= 1'b1;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (fif.f_ready) begin
                        pc      <= next_pc;
                        valid_q <= 1'b0;
                        req_q   <= pc_aligned(next_pc);
                        state   <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign fif.imem_req    = req_q;
    assign fif.imem_addr   = pc;
    assign fif.f_valid     = valid_q;
    assign fif.f_instr     = out_q.instr;
    assign fif.f_pcplus4   = out_q.pcplus4;
    assign fif.f_exc_instr = out_q.exc_instr;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the 5-stage MIPS pipeline: owns the PC register and issues instruction reads on the sram-like instruction port (req/addr_ok/data_ok).
- Packages each returned instruction with its pcplus4 and address-error flag, then hands it to the fetch/decode pipeline register through a valid/ready handshake.
- Producer side of the decode-stage interface: consumes the redirect outputs of decode (branch/jump/jr targets) and an exception redirect from the commit side.

Parameters:
- PC_RESET, 32'hBFC0_0000, PC after reset.
- EXC_VECTOR, 32'hBFC0_0380, redirect target on exception flush.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- imem_req  out  1  instruction read request
- imem_addr  out  32  request address (word aligned)
- imem_addr_ok  in  1  request accepted this cycle
- imem_data_ok  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- f_valid  out  1  dataF fields below are valid
- f_ready  in  1  fetch/decode register accepts (= ~stallD)
- f_instr  out  32  instruction (0 when address error)
- f_pcplus4  out  32  PC of instruction + 4
- f_exc_instr  out  1  instruction address error (pc[1:0] != 0)
- branch_taken  in  1  decode: conditional branch taken
- jump  in  1  decode: J/JAL/JR/JALR
- jr  in  1  decode: register jump
- pcbranch  in  32  branch target
- pcjump  in  32  J/JAL target
- pcjr  in  32  JR/JALR target (decode srca)
- redirect_valid  in  1  decode instruction is valid this cycle (qualifies redirect inputs)
- flush  in  1  exception flush (highest priority)

Behaviour:
- Reset: pc = PC_RESET; imem_req=0; f_valid=0; f_instr=0; f_pcplus4=0; f_exc_instr=0; state IDLE; no pending redirect or discard.
- Redirect target: jr ? pcjr : jump ? pcjump : pcbranch. Taken when redirect_valid && (branch_taken || jump).
- Delay slot: a redirect never cancels the fetch that is in flight or held, since that fetch is the delay slot. The target is latched into pend_pc/pend_v and becomes the next fetch PC once the in-flight fetch completes. Without pend_v, next PC = pc + 4.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: on the cycle after reset, go to REQ.
  - REQ: imem_req=1 with imem_addr=pc. Hold the request until imem_addr_ok, then go to WAIT. If pc[1:0]!=0, issue no request: load the output register with instr=0, exc=1, pcplus4=pc+4, and go to HOLD.
  - WAIT: on imem_data_ok, load the output register with rdata, pc+4, exc=0 and go to HOLD. If discard is set, drop the data, clear discard, and go to REQ.
  - HOLD: f_valid=1. On f_ready, advance pc (pend_pc if pend_v, else pc+4), clear pend_v, and go to REQ.
- Exactly one outstanding request; imem_addr is stable while imem_req=1 and !imem_addr_ok.
- Output register: f_valid asserts the cycle after data_ok, so minimum latency is request accept → f_valid = 2 cycles. Outputs stay stable while f_valid && !f_ready.
- Flush (priority over every other input):
  - pc = EXC_VECTOR; pend_v cleared; f_valid=0.
  - In WAIT: set discard and stay in WAIT until data_ok.
  - In REQ with imem_req high and addr_ok in the same cycle: treat as accepted, set discard, go to WAIT.
  - In any other state: go to REQ next cycle.
- Redirect arriving in the same cycle as the HOLD handshake: the target is used directly as the next pc and is not latched.
- A second redirect while pend_v is set is ignored; decode cannot issue two in a row because of the delay slot.
- Asynchronous reset mid-transaction: return to reset values immediately. The memory side is reset by the same resetn, so no discard is carried across reset.
- pc + 4 wraps modulo 2^32.

Decomposition:
- Shared package: PC_RESET, EXC_VECTOR, fetch_state_t enum {IDLE, REQ, WAIT, HOLD}, and the fetch_data_t field widths matching the dataF struct consumed by the fetch/decode register.
- One sub-module, fetch_pc_sel: combinational next-PC mux (flush / redirect / pending / +4) plus the pend_pc register.

Test Plan:
- Reset release, memory with addr_ok immediate and data_ok 1 cycle later, f_ready=1 → imem_addr sequence BFC00000, BFC00004, BFC00008; f_pcplus4 = BFC00004 on first f_valid, two cycles after accept.
- BEQ taken with pcbranch=BFC00100 while fetching BFC00008 → f_pcplus4=BFC0000C (delay slot) is delivered, then next imem_addr=BFC00100.
- f_ready=0 for 5 cycles in HOLD → f_instr and f_pcplus4 stable, imem_req=0; release → next request issued the following cycle.
- jr with pcjr=BFC00202 → delay slot delivered, no memory request; f_exc_instr=1, f_instr=0, f_pcplus4=BFC00206.
- flush in WAIT, data_ok 3 cycles later with 0x12345678 → data not presented (f_valid stays 0); next imem_addr=BFC00380.
- addr_ok stalled 4 cycles → imem_req and imem_addr=BFC00004 held constant until accept.
